// File: rtl/cdc_vector_stable_strobe.sv
// rtl/cdc_vector_stable_strobe.sv - commits a CDC vector only after it has been stable for STABLE_CYCLES clocks
//
// Purpose:
//   Sits in the destination clock domain behind a vector CDC. The CDC output can
//   step through intermediate values, so a new value is committed only once it
//   has been sampled unchanged on STABLE_CYCLES consecutive rising edges. Each
//   commit is offered once on a valid/ready interface.
//
// Ports:
//   clk          destination-domain clock, rising edge
//   rst_n        synchronous active-low reset
//   data_in      vector from the CDC, already synchronous to clk
//   out_data     last committed value, held between commits
//   out_valid    committed value awaiting acceptance
//   out_ready    consumer accepts out_data when high with out_valid
//   out_stale    data_in differed from out_data at the last edge while out_valid
//   change_count saturating count of accepted commits
//                (only when CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN is defined)
//
// Optional feature macro: CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN

module cdc_vector_stable_strobe #(
  parameter int DATA_WIDTH    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_stale
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] change_count
`endif
);

  generate
    if (DATA_WIDTH < 1 || STABLE_CYCLES < 1 || COUNT_WIDTH < 1) begin : g_param_check
      $error("cdc_vector_stable_strobe: DATA_WIDTH, STABLE_CYCLES and COUNT_WIDTH must be >= 1");
    end
  endgenerate

  // Counter holds at most STABLE_CYCLES-1, so clog2(STABLE_CYCLES+1) bits never wrap.
  localparam int CNT_W = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample, a change commits directly from IDLE.
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_PENDING  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [DATA_WIDTH-1:0]   r_cand;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_stale;

  logic                    w_neq_ref;
  logic                    w_eq_cand;
  logic                    w_accept;

  assign w_neq_ref = (data_in != r_out_data);
  assign w_eq_cand = (data_in == r_cand);
  assign w_accept  = (r_state == S_PENDING) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_neq_ref) begin
          w_state_nxt = ONE_SHOT ? S_PENDING : S_SETTLING;
        end
      end
      S_SETTLING: begin
        // cand never equals out_data, so the candidate match and the
        // glitch-return match are mutually exclusive.
        if (w_eq_cand) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_PENDING;
          end
        end else if (!w_neq_ref) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PENDING: begin
        // The handshake edge does not sample data_in; IDLE looks at it next edge.
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (r_state == S_PENDING);
    out_data  = r_out_data;
    out_stale = r_out_stale;
  end

  // Datapath: committed value, candidate, stability count, stale flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_out_stale <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_neq_ref) begin
            if (ONE_SHOT) begin
              r_out_data <= data_in;
            end else begin
              r_cand <= data_in;
              r_cnt  <= CNT_ONE;
            end
          end
        end
        S_SETTLING: begin
          if (w_eq_cand) begin
            if (r_cnt == CNT_LAST) begin
              r_out_data <= r_cand;
              r_cnt      <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (!w_neq_ref) begin
            r_cnt <= '0;
          end else begin
            r_cand <= data_in;
            r_cnt  <= CNT_ONE;
          end
        end
        S_PENDING: begin
          if (out_ready) begin
            r_out_stale <= 1'b0;
          end else begin
            r_out_stale <= w_neq_ref;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_change_count;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_change_count <= '0;
    end else if (w_accept && (r_change_count != {COUNT_WIDTH{1'b1}})) begin
      r_change_count <= r_change_count + COUNT_WIDTH'(1);
    end
  end

  assign change_count = r_change_count;
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_cdc_vector_stable_strobe.sv
// tb/tb_cdc_vector_stable_strobe.sv - self-checking bench for cdc_vector_stable_strobe
module tb_cdc_vector_stable_strobe;

  localparam int CW      = 4;
  localparam int CC_MAX  = (1 << CW) - 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       out_ready;
  logic [7:0] data_in;

  logic [7:0] od4, od1;
  logic       ov4, ov1, os4, os1;
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
  logic [CW-1:0] cc4, cc1;
`endif

  cdc_vector_stable_strobe #(.DATA_WIDTH(8), .STABLE_CYCLES(4), .COUNT_WIDTH(CW)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .out_stale(os4)
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    , .change_count(cc4)
`endif
  );

  cdc_vector_stable_strobe #(.DATA_WIDTH(8), .STABLE_CYCLES(1), .COUNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_stale(os1)
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    , .change_count(cc1)
`endif
  );

  typedef logic [7:0] byte_q_t [$];

  // Reference model: a value commits when the last S samples taken while
  // filtering are all equal and differ from the committed value.
  logic [7:0] m4_comm, m1_comm;
  logic       m4_val, m1_val, m4_stl, m1_stl;
  int         m4_cc, m1_cc;
  byte_q_t    h4, h1;

  int n_vec = 0;
  int n_err = 0;
  int strobes4 = 0;
  int strobes1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mstep(input int s, inout logic [7:0] comm, inout logic val,
                       inout logic stl, inout int cc, inout byte_q_t h);
    bit all_eq;
    if (!rst_n) begin
      comm = 8'h00; val = 1'b0; stl = 1'b0; cc = 0;
      h.delete();
    end else if (val) begin
      if (out_ready) begin
        val = 1'b0; stl = 1'b0;
        if (cc < CC_MAX) cc++;
        h.delete();
      end else begin
        stl = (data_in != comm);
      end
    end else begin
      h.push_back(data_in);
      if (h.size() > s) void'(h.pop_front());
      if (h.size() == s) begin
        all_eq = 1'b1;
        foreach (h[i]) if (h[i] != data_in) all_eq = 1'b0;
        if (all_eq && data_in != comm) begin
          comm = data_in; val = 1'b1; stl = 1'b0;
          h.delete();
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    mstep(4, m4_comm, m4_val, m4_stl, m4_cc, h4);
    mstep(1, m1_comm, m1_val, m1_stl, m1_cc, h1);
    #1;
    if (ov4) strobes4++;
    if (ov1) strobes1++;
    chk("s4.out_data",  od4, m4_comm);
    chk("s4.out_valid", ov4, m4_val);
    chk("s4.out_stale", os4, m4_stl);
    chk("s1.out_data",  od1, m1_comm);
    chk("s1.out_valid", ov1, m1_val);
    chk("s1.out_stale", os1, m1_stl);
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    chk("s4.change_count", cc4, m4_cc);
    chk("s1.change_count", cc1, m1_cc);
`endif
  endtask

  initial begin
    int run;
    rst_n = 1'b0; data_in = 8'h00; out_ready = 1'b1;
    m4_comm = 8'h00; m1_comm = 8'h00; m4_val = 1'b0; m1_val = 1'b0;
    m4_stl = 1'b0; m1_stl = 1'b0; m4_cc = 0; m1_cc = 0;

    // Reset state
    step(); step();
    chk("reset.out_data", od4, 8'h00);
    chk("reset.out_valid", ov4, 1'b0);
    chk("reset.out_stale", os4, 1'b0);
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    chk("reset.change_count", cc4, 0);
`endif

    // Hold zero: nothing commits
    rst_n = 1'b1;
    strobes4 = 0;
    repeat (20) step();
    chk("idle.no_strobe", strobes4, 0);
    chk("idle.out_data", od4, 8'h00);

    // 0x00 -> 0x5A: valid after the 4th sampling edge, one cycle wide
    data_in = 8'h5A;
    repeat (3) step();
    chk("5a.before_4th", ov4, 1'b0);
    step();
    chk("5a.valid", ov4, 1'b1);
    chk("5a.data", od4, 8'h5A);
    step();
    chk("5a.pulse_1cyc", ov4, 1'b0);
    chk("5a.held", od4, 8'h5A);
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    chk("5a.change_count", cc4, 1);
`endif

    // Glitch back to the committed value: no strobe
    strobes4 = 0;
    data_in = 8'h13; step(); step();
    data_in = 8'h5A; repeat (6) step();
    chk("glitch.no_strobe", strobes4, 0);
    chk("glitch.out_data", od4, 8'h5A);

    // Intermediate 0x13 then settled 0x77: one strobe carrying 0x77
    data_in = 8'h13; step(); step();
    data_in = 8'h77; repeat (3) step();
    chk("77.before_4th", ov4, 1'b0);
    step();
    chk("77.valid", ov4, 1'b1);
    chk("77.data", od4, 8'h77);
    step();
    chk("77.single_strobe", strobes4, 1);

    // Backpressure with a change while pending
    out_ready = 1'b0;
    data_in = 8'h21; repeat (4) step();
    chk("bp.valid", ov4, 1'b1);
    chk("bp.data", od4, 8'h21);
    chk("bp.not_stale", os4, 1'b0);
    data_in = 8'h22; step();
    chk("bp.stale", os4, 1'b1);
    chk("bp.data_frozen", od4, 8'h21);
    repeat (3) step();
    chk("bp.valid_held", ov4, 1'b1);
    chk("bp.data_held", od4, 8'h21);
    out_ready = 1'b1; step();
    chk("bp.accepted", ov4, 1'b0);
    chk("bp.stale_clr", os4, 1'b0);
    repeat (3) step();
    chk("bp.resettle", ov4, 1'b0);
    step();
    chk("bp.22_valid", ov4, 1'b1);
    chk("bp.22_data", od4, 8'h22);
    step();

    // Reset mid-settle abandons the candidate
    data_in = 8'h40; step(); step();
    rst_n = 1'b0; step();
    chk("rst_mid.valid", ov4, 1'b0);
    chk("rst_mid.data", od4, 8'h00);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_mid.settling", ov4, 1'b0);
    step();
    chk("rst_mid.40_valid", ov4, 1'b1);
    chk("rst_mid.40_data", od4, 8'h40);
    step();

    // STABLE_CYCLES=1: alternate 0x01/0x02, commit then bubble each time
    strobes1 = 0;
    for (int k = 0; k < 20; k++) begin
      data_in = ((k >> 1) & 1) ? 8'h02 : 8'h01;
      step();
    end
    chk("s1.toggle_strobes", strobes1, 10);
`ifdef CDC_VECTOR_STABLE_STROBE_CHANGE_COUNT_EN
    for (int k = 20; k < 60; k++) begin
      data_in = ((k >> 1) & 1) ? 8'h02 : 8'h01;
      step();
    end
    chk("s1.count_saturated", cc1, CC_MAX);
`endif

    // Randomized runs with random backpressure and occasional reset
    for (int k = 0; k < 120; k++) begin
      data_in = 8'($urandom_range(0, 3) * 8'h11);
      run = $urandom_range(1, 6);
      for (int j = 0; j < run; j++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        rst_n = ($urandom_range(0, 59) != 0);
        step();
      end
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
